// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: execution controller for the single-cycle CPU board build.
// Conditions the board buttons/switch, then issues one-cycle instruction
// enables for single-step, divided free-run and PC breakpoint operation.
// Also keeps the seven-segment display page selector.
module cpu_run_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int RUN_DIV         = 25_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        step_btn,
  input  logic        page_btn,
  input  logic        run_sw,
  input  logic        bp_en,
  input  logic [31:0] bp_addr,
  input  logic [31:0] cur_pc,
  output logic        cpu_ce,
  output logic [1:0]  state,
  output logic        bp_hit,
  output logic [15:0] instr_count,
  output logic [1:0]  page
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DIV_W = $clog2(RUN_DIV);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

  typedef enum logic [1:0] {
    HALT = 2'b00,
    STEP = 2'b01,
    RUN  = 2'b10,
    BRK  = 2'b11
  } st_t;

  // bit 0 = step button, bit 1 = page button, bit 2 = run switch
  logic [2:0]            sync_p0;
  logic [2:0]            sync_p1;
  logic [1:0]            acc;
  logic [1:0]            acc_d;
  logic [1:0]            ev;
  logic [1:0][DB_W-1:0]  db_cnt;
  logic [DIV_W-1:0]      div;
  st_t                   st;

  logic run_s;
  logic step_ev;
  logic page_ev;
  logic bp_match;

  assign run_s    = sync_p1[2];
  assign step_ev  = ev[0];
  assign page_ev  = ev[1];
  assign bp_match = bp_en && (cur_pc == bp_addr);
  assign state    = st;

  // Stage boundary: two-flop synchronizers for the asynchronous board inputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= {run_sw, page_btn, step_btn};
      sync_p1 <= sync_p0;
    end
  end

  // Stage boundary: button debouncers; accepted level moves only after a full
  // run of differing samples, and a registered rising-edge pulse is produced
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc    <= '0;
      acc_d  <= '0;
      ev     <= '0;
      db_cnt <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync_p1[i] != acc[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            acc[i]    <= sync_p1[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
      acc_d <= acc;
      ev    <= acc & ~acc_d;
    end
  end

  // Display page selector, independent of the run state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      page <= '0;
    end else if (page_ev) begin
      page <= page + 1'b1;
    end
  end

  // Run-control FSM with registered enable, breakpoint flag and pulse counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st          <= HALT;
      cpu_ce      <= 1'b0;
      bp_hit      <= 1'b0;
      div         <= '0;
      instr_count <= '0;
    end else begin
      cpu_ce <= 1'b0;
      if (cpu_ce) begin
        instr_count <= instr_count + 1'b1;
      end
      case (st)
        HALT: begin
          if (step_ev) begin
            st     <= STEP;
            cpu_ce <= 1'b1;
          end else if (run_s) begin
            st  <= RUN;
            div <= '0;
          end
        end
        STEP: begin
          st <= HALT;
        end
        RUN: begin
          if (!run_s) begin
            st  <= HALT;
            div <= '0;
          end else if (bp_match) begin
            st     <= BRK;
            bp_hit <= 1'b1;
          end else if (div == DIV_LAST) begin
            cpu_ce <= 1'b1;
            div    <= '0;
          end else begin
            div <= div + 1'b1;
          end
        end
        BRK: begin
          if (!run_s) begin
            st     <= HALT;
            bp_hit <= 1'b0;
          end else if (step_ev) begin
            st     <= STEP;
            cpu_ce <= 1'b1;
            bp_hit <= 1'b0;
          end
        end
        default: begin
          st     <= HALT;
          bp_hit <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Testbench for cpu_run_ctrl: directed steps with a pulse scoreboard.
module tb_cpu_run_ctrl;

  localparam int DB  = 4;
  localparam int DIV = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        step_btn;
  logic        page_btn;
  logic        run_sw;
  logic        bp_en;
  logic [31:0] bp_addr;
  logic [31:0] cur_pc;
  logic        cpu_ce;
  logic [1:0]  state;
  logic        bp_hit;
  logic [15:0] instr_count;
  logic [1:0]  page;

  cpu_run_ctrl #(.DEBOUNCE_CYCLES(DB), .RUN_DIV(DIV)) dut (
    .clock(clock), .reset(reset), .step_btn(step_btn), .page_btn(page_btn),
    .run_sw(run_sw), .bp_en(bp_en), .bp_addr(bp_addr), .cur_pc(cur_pc),
    .cpu_ce(cpu_ce), .state(state), .bp_hit(bp_hit),
    .instr_count(instr_count), .page(page)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Model CPU core: PC advances by 4 on each instruction enable
  logic pc_clr = 1'b0;
  initial cur_pc = 32'h0;
  always @(posedge clock) begin
    if (pc_clr) cur_pc <= 32'h0;
    else if (cpu_ce) cur_pc <= cur_pc + 32'd4;
  end

  typedef struct {
    int          cyc;
    int          tol;
    logic [15:0] cnt;
  } exp_t;
  exp_t q[$];
  logic [15:0] exp_cnt = 16'h0;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    n_chk++;
    assert (obs >= lo && obs <= hi) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic expect_pulse(input int at, input int tol);
    exp_t e;
    e.cyc = at;
    e.tol = tol;
    e.cnt = exp_cnt;
    q.push_back(e);
    exp_cnt = exp_cnt + 16'd1;
  endtask

  // Pulse monitor: every enable must be expected, one cycle wide, on time
  logic ce_prev = 1'b0;
  always @(negedge clock) begin
    if (cpu_ce) begin
      chk("ce_width", {31'b0, ce_prev}, 32'h0);
      chk_rng("pulse_expected", q.size(), 1, 1000);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk("pulse_count", {16'h0, instr_count}, {16'h0, e.cnt});
        chk_rng("pulse_cycle", cyc, e.cyc - e.tol, e.cyc + e.tol);
      end
    end
    ce_prev <= cpu_ce;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int s;
    reset = 1'b0; step_btn = 0; page_btn = 0; run_sw = 0;
    bp_en = 0; bp_addr = 32'h0;

    // Reset held with inputs toggling
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      step_btn = i[0]; page_btn = ~i[0]; run_sw = i[0];
      #1;
      chk("rst_ce", {31'b0, cpu_ce}, 32'h0);
      chk("rst_state", {30'b0, state}, 32'h0);
      chk("rst_bp_hit", {31'b0, bp_hit}, 32'h0);
      chk("rst_count", {16'h0, instr_count}, 32'h0);
      chk("rst_page", {30'b0, page}, 32'h0);
    end
    @(negedge clock);
    step_btn = 0; page_btn = 0; run_sw = 0;
    reset = 1'b1;
    tick(50);
    chk("idle_state", {30'b0, state}, 32'h0);
    chk("idle_count", {16'h0, instr_count}, 32'h0);

    // Page presses: 1,2,3,0,1
    for (int i = 1; i <= 5; i++) begin
      page_btn = 1; tick(10);
      page_btn = 0; tick(10);
      chk("page_seq", {30'b0, page}, i % 4);
    end

    // Single step held for 20 cycles
    c = cyc;
    step_btn = 1;
    expect_pulse(c + DB + 4, 1);
    tick(20);
    step_btn = 0;
    tick(12);
    chk("step_count", {16'h0, instr_count}, 32'd1);
    chk("step_state", {30'b0, state}, 32'h0);

    // Bouncy press: isolated one-cycle glitches
    repeat (5) begin
      step_btn = 1; tick(1);
      step_btn = 0; tick(2);
    end
    tick(20);
    chk("bounce_count", {16'h0, instr_count}, 32'd1);

    // Free run for 100 cycles
    c = cyc;
    run_sw = 1;
    for (int k = 0; k < 12; k++) expect_pulse(c + 3 + DIV + DIV * k, 0);
    tick(5);
    chk("run_state", {30'b0, state}, 32'h2);
    tick(95);
    run_sw = 0;
    tick(30);
    chk("run_stop_state", {30'b0, state}, 32'h0);
    chk("run_count", {16'h0, instr_count}, 32'd13);
    chk("run_sb_empty", q.size(), 32'h0);

    // Breakpoint at PC 0x0C
    pc_clr = 1; tick(1); pc_clr = 0;
    bp_en = 1; bp_addr = 32'h0C;
    c = cyc;
    run_sw = 1;
    for (int k = 0; k < 3; k++) expect_pulse(c + 3 + DIV + DIV * k, 0);
    tick(40);
    chk("bp_state", {30'b0, state}, 32'h3);
    chk("bp_hit", {31'b0, bp_hit}, 32'h1);
    chk("bp_pc", cur_pc, 32'h0C);
    chk("bp_count", {16'h0, instr_count}, 32'd16);

    // Step out of the breakpoint, then RUN resumes
    s = cyc;
    step_btn = 1;
    expect_pulse(s + DB + 4, 1);
    expect_pulse(s + DB + 4 + 2 + DIV, 1);
    expect_pulse(s + DB + 4 + 2 + 2 * DIV, 1);
    tick(4);
    chk("bp_hold", {31'b0, bp_hit}, 32'h1);
    tick(8);
    chk("resume_state", {30'b0, state}, 32'h2);
    chk("resume_bp_hit", {31'b0, bp_hit}, 32'h0);
    step_btn = 0;
    tick(16);
    run_sw = 0; bp_en = 0;
    tick(20);
    chk("resume_stop", {30'b0, state}, 32'h0);
    chk("resume_sb_empty", q.size(), 32'h0);
    chk("resume_count", {16'h0, instr_count}, 32'd19);

    // Counter wrap
    force dut.instr_count = 16'hFFFF;
    tick(1);
    release dut.instr_count;
    exp_cnt = 16'hFFFF;
    tick(1);
    chk("wrap_preload", {16'h0, instr_count}, 32'hFFFF);
    c = cyc;
    step_btn = 1;
    expect_pulse(c + DB + 4, 1);
    tick(20);
    step_btn = 0;
    tick(12);
    chk("wrap_count", {16'h0, instr_count}, {16'h0, exp_cnt});
    chk("wrap_zero", {16'h0, instr_count}, 32'h0);

    // Asynchronous reset during the STEP cycle
    c = cyc;
    step_btn = 1;
    expect_pulse(c + DB + 4, 1);
    for (int i = 0; i < 20 && !cpu_ce; i++) @(negedge clock);
    chk("arst_ce_seen", {31'b0, cpu_ce}, 32'h1);
    #1 reset = 1'b0;
    #1;
    chk("arst_ce", {31'b0, cpu_ce}, 32'h0);
    chk("arst_count", {16'h0, instr_count}, 32'h0);
    chk("arst_state", {30'b0, state}, 32'h0);
    step_btn = 0;
    @(negedge clock);
    reset = 1'b1;
    exp_cnt = 16'h0;
    tick(20);
    chk("arst_after_state", {30'b0, state}, 32'h0);
    chk("final_sb_empty", q.size(), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
